// File: rtl/nv_nvdla_pdp_rdma_rdreq_sched.sv
// PDP RDMA read-request scheduler: routes requests to MCIF/CVIF under a credit limit.
// Optional stall counter enabled by NVDLA_PDP_RDMA_PERF_STALL_EN.
module nv_nvdla_pdp_rdma_rdreq_sched (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        reg2dp_op_en,
    input  logic        reg2dp_src_ram_type,
    input  logic [7:0]  reg2dp_cdt_limit,
    input  logic        ig_req_valid,
    output logic        ig_req_ready,
    input  logic [78:0] ig_req_pd,
    output logic        pdp2mcif_rd_req_valid,
    input  logic        pdp2mcif_rd_req_ready,
    output logic [78:0] pdp2mcif_rd_req_pd,
    output logic        pdp2cvif_rd_req_valid,
    input  logic        pdp2cvif_rd_req_ready,
    output logic [78:0] pdp2cvif_rd_req_pd,
    input  logic        mcif_cdt_pop,
    input  logic        cvif_cdt_pop,
    output logic        sched_idle,
    output logic        cdt_err,
    output logic [31:0] dp2reg_perf_read_stall
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       cdt_err_q, cdt_err_d;

    logic [8:0] limit;
    logic       avail;
    logic       sel_rdy;
    logic       accept;
    logic       sel_pop;
    logic       unsel_pop;
    logic       go;

    always_comb begin
        limit     = (reg2dp_cdt_limit == 8'd0) ? 9'd256 : {1'b0, reg2dp_cdt_limit};
        // Leaving RUN (op_en low) must block requests in that very cycle.
        avail     = (state_q == RUN) && reg2dp_op_en && (cnt_q < limit);
        sel_rdy   = sel_q ? pdp2mcif_rd_req_ready : pdp2cvif_rd_req_ready;
        sel_pop   = sel_q ? mcif_cdt_pop : cvif_cdt_pop;
        unsel_pop = sel_q ? cvif_cdt_pop : mcif_cdt_pop;

        ig_req_ready          = avail && sel_rdy;
        accept                = ig_req_valid && ig_req_ready;
        pdp2mcif_rd_req_valid = sel_q && ig_req_valid && avail;
        pdp2cvif_rd_req_valid = !sel_q && ig_req_valid && avail;
        pdp2mcif_rd_req_pd    = sel_q ? ig_req_pd : 79'd0;
        pdp2cvif_rd_req_pd    = sel_q ? 79'd0 : ig_req_pd;
        sched_idle            = (state_q == IDLE);
        cdt_err               = cdt_err_q;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        go      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (reg2dp_op_en) begin
                    state_d = RUN;
                    sel_d   = reg2dp_src_ram_type;
                    go      = 1'b1;
                end
            end
            RUN: begin
                if (!reg2dp_op_en) state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_q == 9'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        cdt_err_d = cdt_err_q;
        if (accept && !sel_pop) begin
            cnt_d = cnt_q + 9'd1;
        end else if (sel_pop && !accept && cnt_q != 9'd0) begin
            cnt_d = cnt_q - 9'd1;
        end
        if ((sel_pop && cnt_q == 9'd0) || unsel_pop) cdt_err_d = 1'b1;
        if (go) cdt_err_d = 1'b0;
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 9'd0;
            sel_q     <= 1'b0;
            cdt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            cdt_err_q <= cdt_err_d;
        end
    end

`ifdef NVDLA_PDP_RDMA_PERF_STALL_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (go) begin
            stall_d = 32'd0;
        end else if ((state_q == RUN) && ig_req_valid && !ig_req_ready
                     && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) stall_q <= 32'd0;
        else                stall_q <= stall_d;
    end

    assign dp2reg_perf_read_stall = stall_q;
`else
    assign dp2reg_perf_read_stall = 32'd0;
`endif

endmodule
